muldiv_sequencer: RTL

//  Multi-cycle multiply/divide controller for the pipelined MIPS core. Accepts mult/multu/div/divu

---
 rtl/muldiv_sequencer_if.sv | 38 +++
 rtl/muldiv_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Bundles the EX-stage start request, the WB-stage mthi/mtlo write, the
//   ID-stage hazard requests and the HI/LO / busy / stall outputs of the
//   multiply/divide sequencer.
//   master : the pipeline side (drives start/mt/requests, reads results)
//   slave  : the sequencer side
//   Signals: startE, opE[1:0], srcaE, srcbE, cancelE, mthiW, mtloW, mtdataW,
//            mfreqD, mdreqD (to sequencer); busy, stallD, hi, lo (from it).
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             cancelE;
  logic             mthiW;
  logic             mtloW;
  logic [WIDTH-1:0] mtdataW;
  logic             mfreqD;
  logic             mdreqD;
  logic             busy;
  logic             stallD;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output startE, opE, srcaE, srcbE, cancelE, mthiW, mtloW, mtdataW,
           mfreqD, mdreqD,
    input  busy, stallD, hi, lo
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, cancelE, mthiW, mtloW, mtdataW,
           mfreqD, mdreqD,
    output busy, stallD, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit owning the HI/LO registers.
//   mult/multu: shift-add over WIDTH cycles, {hi,lo} = product.
//   div/divu  : restoring divide over WIDTH cycles, lo = quotient, hi = remainder.
//   Operands are converted to magnitudes at start; the sign is fixed up in FIX.
//   Ports: clk, reset (async, active-high), md (muldiv_sequencer_if.slave).
//   Optional feature: define MULDIV_FAST_MUL_EN to compute mult/multu with a
//   single registered WIDTHxWIDTH multiplier (busy for 2 cycles instead of
//   WIDTH+1). Divide timing is unaffected.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave md
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   b_q, b_d;          // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   rawa_q, rawa_d;    // unmodified dividend, returned on divide-by-zero
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;      // negate product / quotient
  logic               rneg_q, rneg_d;    // negate remainder

  logic               busy, start_ok, is_signed, fast_pend;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_diff, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign start_ok  = (state_q == S_IDLE) && md.startE && !md.cancelE;
  assign is_signed = !md.opE[0];

`ifdef MULDIV_FAST_MUL_EN
  // A multiply entering FIX with cnt==0 came straight from IDLE and still
  // needs its product registered before the write-back cycle.
  assign fast_pend = (state_q == S_FIX) && !is_div_q && (cnt_q == '0);
`else
  assign fast_pend = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = md.opE[1] ? S_RUN : S_FIX;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = fast_pend ? S_FIX : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An mthi/mtlo while busy abandons the operation in flight.
    if (busy && (md.mthiW || md.mtloW)) state_d = S_IDLE;
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    md.busy   = busy;
    md.stallD = busy && (md.mfreqD || md.mdreqD);
    md.hi     = hi_q;
    md.lo     = lo_q;
  end

  // Datapath
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    rawa_d   = rawa_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;

    // One shift-add step: add multiplicand when the multiplier LSB is set, shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // One restoring step: shift the next dividend bit into the remainder.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - b_q;

    prod_fix = neg_2w(acc_q, neg_q);
    if (is_div_q) begin
      if (b_q == '0) begin
        res_lo = '1;
        res_hi = rawa_q;
      end else begin
        res_lo = neg_w(acc_q[WIDTH-1:0], neg_q);
        res_hi = neg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
      end
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          is_div_d = md.opE[1];
          neg_d    = is_signed && (md.srcaE[WIDTH-1] ^ md.srcbE[WIDTH-1]);
          rneg_d   = is_signed && md.srcaE[WIDTH-1];
          acc_d    = {{WIDTH{1'b0}}, abs_w(md.srcaE, is_signed)};
          b_d      = abs_w(md.srcbE, is_signed);
          rawa_d   = md.srcaE;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (rem_sh >= {1'b0, b_q}) acc_d = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
          else                       acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        if (fast_pend) begin
`ifdef MULDIV_FAST_MUL_EN
          acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, b_q};
`endif
          cnt_d = CNT_W'(1);
        end else begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: ;
    endcase

    // mt writes take priority for the register they target.
    if (md.mthiW) hi_d = md.mtdataW;
    if (md.mtloW) lo_d = md.mtdataW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      rawa_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      rawa_q   <= rawa_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

endmodule
